bscan_byte_port: RTL and testbench

BSCAN_BYTE_PORT -- requirements
Module: bscan_byte_port

---
 rtl/bscan_pkg.sv | 20 ++
 rtl/bscan_byte_port.sv | 106 ++++++++++
 tb/tb_bscan_byte_port.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bscan_pkg.sv
// ---------------------------------------------------------------------------
// bscan_pkg
// Purpose : Constants shared by the USER-register byte port, the user logic
//           that consumes its bytes and the bench.
// Contents: RESULT_WIDTH   - width of the readback word scanned out on tdo
//           BYTE_WIDTH     - exact DR scan length that carries one byte
//           CNT_WIDTH      - width of the saturating scan bit counter
//           CNT_MAX        - saturation value of the bit counter
//           CNT_BYTE       - counter value that qualifies a byte scan
// ---------------------------------------------------------------------------
package bscan_pkg;

  localparam int RESULT_WIDTH = 32;
  localparam int BYTE_WIDTH   = 8;
  localparam int CNT_WIDTH    = 6;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_BYTE = CNT_WIDTH'(BYTE_WIDTH);

endpackage : bscan_pkg

// File: rtl/bscan_byte_port.sv
// ---------------------------------------------------------------------------
// bscan_byte_port
// Purpose : USER data register behind a JTAG TAP. A read scan returns the
//           current result word on tdo (LSB first); a scan of exactly
//           BYTE_WIDTH bits followed by update_dr delivers one byte into a
//           single-entry holding register with valid/ready handshake.
// Ports   : tck              - sole clock, rising edge
//           test_logic_reset - synchronous active-high reset
//           tdi / tdo        - serial data in / out (LSB first)
//           ir_is_user       - USER instruction selected, gates all DR actions
//           run_test_idle    - TAP idle indication (no effect on state)
//           capture_dr, shift_dr, update_dr - TAP DR state decodes
//           result, result_valid - readback word and its qualifier
//           byte_data, byte_valid, byte_ready - received byte handshake
//           overrun          - sticky lost-byte flag, cleared only by reset
// ---------------------------------------------------------------------------
module bscan_byte_port
  import bscan_pkg::*;
(
  input  logic                    tck,
  input  logic                    test_logic_reset,
  input  logic                    tdi,
  output logic                    tdo,
  input  logic                    ir_is_user,
  input  logic                    run_test_idle,
  input  logic                    capture_dr,
  input  logic                    shift_dr,
  input  logic                    update_dr,
  input  logic [RESULT_WIDTH-1:0] result,
  input  logic                    result_valid,
  output logic [BYTE_WIDTH-1:0]   byte_data,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic                    overrun
);

  logic [RESULT_WIDTH-1:0] r_shift;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [BYTE_WIDTH-1:0]   r_byte_data;
  logic                    r_byte_valid;
  logic                    r_overrun;

  logic                    w_do_capture;
  logic                    w_do_shift;
  logic                    w_byte_arrive;
  logic                    w_byte_accept;
  logic [BYTE_WIDTH-1:0]   w_new_byte;
  logic                    w_unused;

  // run_test_idle is informational only.
  assign w_unused = run_test_idle;

  // Overlapping decodes resolve as capture > shift > update.
  assign w_do_capture  = ir_is_user & capture_dr;
  assign w_do_shift    = ir_is_user & ~capture_dr & shift_dr;
  assign w_byte_arrive = ir_is_user & ~capture_dr & ~shift_dr & update_dr
                         & (r_cnt == CNT_BYTE);
  assign w_byte_accept = r_byte_valid & byte_ready;

  // Bits enter at the MSB, so after BYTE_WIDTH shifts the first bit received
  // (the byte LSB) sits at the bottom of the top BYTE_WIDTH-bit field.
  assign w_new_byte = r_shift[RESULT_WIDTH-1 -: BYTE_WIDTH];

  // Scan path: shift register and saturating bit counter.
  always_ff @(posedge tck) begin
    if (test_logic_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_do_capture) begin
      r_shift <= result_valid ? result : '0;
      r_cnt   <= '0;
    end else if (w_do_shift) begin
      r_shift <= {tdi, r_shift[RESULT_WIDTH-1:1]};
      // Saturate so very long scans can never wrap back to BYTE_WIDTH.
      if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Single-entry holding register. An arrival in the same cycle as an
  // acceptance refills the entry; an arrival into a full, stalled entry is
  // dropped and flagged.
  always_ff @(posedge tck) begin
    if (test_logic_reset) begin
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_byte_arrive) begin
      if (!r_byte_valid || byte_ready) begin
        r_byte_data  <= w_new_byte;
        r_byte_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (w_byte_accept) begin
      r_byte_valid <= 1'b0;
    end
  end

  assign tdo        = r_shift[0];
  assign byte_data  = r_byte_data;
  assign byte_valid = r_byte_valid;
  assign overrun    = r_overrun;

endmodule : bscan_byte_port

// File: tb/tb_bscan_byte_port.sv
// ---------------------------------------------------------------------------
// tb_bscan_byte_port
// Purpose : Self-checking bench for bscan_byte_port. Directed scenarios for
//           readback, byte delivery, overrun, gating and reset, followed by
//           randomized scan transactions compared cycle by cycle against a
//           bit-stream reference model.
// ---------------------------------------------------------------------------
module tb_bscan_byte_port;
  import bscan_pkg::*;

  logic                    tck = 1'b0;
  logic                    test_logic_reset;
  logic                    tdi;
  logic                    tdo;
  logic                    ir_is_user;
  logic                    run_test_idle;
  logic                    capture_dr;
  logic                    shift_dr;
  logic                    update_dr;
  logic [RESULT_WIDTH-1:0] result;
  logic                    result_valid;
  logic [BYTE_WIDTH-1:0]   byte_data;
  logic                    byte_valid;
  logic                    byte_ready;
  logic                    overrun;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_ready = 1'b0;

  // Reference model: the data register seen as a 32-bit bit stream whose
  // head is on tdo, plus the list of tdi bits received since the last
  // capture/reset and the handshake state.
  bit             m_stream[$];
  bit             m_in[$];
  int             m_cnt;
  bit             m_valid;
  bit             m_ovr;
  logic [7:0]     m_data;

  always #5 tck = ~tck;

  bscan_byte_port u_dut (
    .tck              (tck),
    .test_logic_reset (test_logic_reset),
    .tdi              (tdi),
    .tdo              (tdo),
    .ir_is_user       (ir_is_user),
    .run_test_idle    (run_test_idle),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .result           (result),
    .result_valid     (result_valid),
    .byte_data        (byte_data),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .overrun          (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_stream = {};
    for (int i = 0; i < RESULT_WIDTH; i++) m_stream.push_back(1'b0);
    m_in    = {};
    m_cnt   = 0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_data  = 8'h00;
  endtask

  // Apply one rising edge worth of specification rules to the model.
  task automatic model_step();
    bit         accept;
    bit         arrive;
    logic [7:0] nb;
    accept = m_valid && byte_ready;
    arrive = 1'b0;
    nb     = 8'h00;
    if (test_logic_reset) begin
      model_reset();
      return;
    end
    if (ir_is_user) begin
      if (capture_dr) begin
        m_stream = {};
        for (int i = 0; i < RESULT_WIDTH; i++)
          m_stream.push_back(result_valid ? result[i] : 1'b0);
        m_in  = {};
        m_cnt = 0;
      end else if (shift_dr) begin
        void'(m_stream.pop_front());
        m_stream.push_back(tdi);
        m_in.push_back(tdi);
        if (m_cnt < 63) m_cnt++;
      end else if (update_dr && m_cnt == BYTE_WIDTH) begin
        arrive = 1'b1;
        for (int i = 0; i < BYTE_WIDTH; i++) nb[i] = m_in[i];
      end
    end
    if (arrive) begin
      if (!m_valid || byte_ready) begin
        m_data  = nb;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (accept) begin
      m_valid = 1'b0;
    end
  endtask

  // Drive one cycle (from a falling edge), update the model at the rising
  // edge and compare all outputs at the next falling edge.
  task automatic tick(input logic c, input logic s, input logic u, input logic d, input logic r);
    capture_dr       = c;
    shift_dr         = s;
    update_dr        = u;
    tdi              = d;
    test_logic_reset = r;
    run_test_idle    = 1'($urandom);
    if (rand_ready) byte_ready = 1'($urandom);
    @(posedge tck);
    model_step();
    @(negedge tck);
    check("tdo",        32'(tdo),        32'(m_stream[0]));
    check("byte_valid", 32'(byte_valid), 32'(m_valid));
    check("byte_data",  32'(byte_data),  32'(m_data));
    check("overrun",    32'(overrun),    32'(m_ovr));
  endtask

  task automatic write_scan(input logic [7:0] b);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < BYTE_WIDTH; i++) tick(0, 1, 0, b[i], 0);
    tick(0, 0, 1, 0, 0);
  endtask

  task automatic read_scan(input int n, output logic [31:0] got);
    got = '0;
    tick(1, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) begin
      got[k] = tdo;
      tick(0, 1, 0, 0, 0);
    end
    tick(0, 0, 1, 0, 0);
  endtask

  task automatic len_scan(input int n);
    tick(1, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) tick(0, 1, 0, 1'($urandom), 0);
    tick(0, 0, 1, 0, 0);
  endtask

  initial begin
    logic [31:0] got;
    logic        t0;
    int          kind;
    int          len;
    logic [7:0]  b;

    capture_dr = 0; shift_dr = 0; update_dr = 0; tdi = 0;
    ir_is_user = 1; run_test_idle = 0; result = '0; result_valid = 0;
    byte_ready = 1; test_logic_reset = 1;
    model_reset();
    @(negedge tck);

    // Reset state
    tick(0, 0, 0, 0, 1);
    check("rst_tdo", 32'(tdo), 32'd0);
    check("rst_bv",  32'(byte_valid), 32'd0);
    check("rst_bd",  32'(byte_data), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);

    // Byte 0x0A with ready high: one-cycle valid pulse
    write_scan(8'h0A);
    check("w0A_bv",  32'(byte_valid), 32'd1);
    check("w0A_bd",  32'(byte_data), 32'h0A);
    check("w0A_ovr", 32'(overrun), 32'd0);
    tick(0, 0, 0, 0, 0);
    check("w0A_pulse", 32'(byte_valid), 32'd0);
    $display("txn write 0A done");

    // Readback of a valid result
    result = 32'h0000_1234; result_valid = 1;
    read_scan(32, got);
    check("rd1234", got, 32'h0000_1234);
    check("rd1234_bv", 32'(byte_valid), 32'd0);
    $display("txn read %h", got);

    // Invalid result reads zero, then a valid one reads back
    result = 32'hDEAD_BEEF; result_valid = 0;
    read_scan(32, got);
    check("rd_inval", got, 32'h0);
    result_valid = 1;
    read_scan(32, got);
    check("rd_beef", got, 32'hDEAD_BEEF);
    $display("txn read %h", got);

    // Overrun with a stalled consumer
    byte_ready = 0;
    write_scan(8'h3C);
    write_scan(8'h5A);
    check("ovr_bd",  32'(byte_data), 32'h3C);
    check("ovr_flag", 32'(overrun), 32'd1);
    byte_ready = 1;
    tick(0, 0, 0, 0, 0);
    check("ovr_acc_bv", 32'(byte_valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);
    $display("txn overrun 3C/5A done");

    // Scans ignored without USER selected; short scans deliver nothing
    ir_is_user = 0;
    t0 = tdo;
    write_scan(8'hFF);
    check("nouser_bv",  32'(byte_valid), 32'd0);
    check("nouser_tdo", 32'(tdo), 32'(t0));
    ir_is_user = 1;
    len_scan(7);
    check("short_bv", 32'(byte_valid), 32'd0);
    // 72 shifts would alias to 8 without counter saturation
    len_scan(72);
    check("sat_bv", 32'(byte_valid), 32'd0);
    $display("txn gating/short/long scans done");

    // Reset mid-scan aborts the byte
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 1, 0);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 1, 0, 0);
    check("abort_bv",  32'(byte_valid), 32'd0);
    check("abort_bd",  32'(byte_data), 32'd0);
    check("abort_ovr", 32'(overrun), 32'd0);
    check("abort_tdo", 32'(tdo), 32'd0);
    $display("txn reset mid-scan done");

    // Randomized transactions
    rand_ready = 1'b1;
    for (int t = 0; t < 300; t++) begin
      kind = int'($urandom_range(0, 5));
      ir_is_user = ($urandom_range(0, 9) != 0);
      case (kind)
        0, 1, 2: begin
          b = 8'($urandom);
          write_scan(b);
          $display("txn %0d write %h user=%0d bv=%0d bd=%h ovr=%0d", t, b, ir_is_user, byte_valid, byte_data, overrun);
        end
        3: begin
          len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 80)) : int'($urandom_range(0, 12));
          len_scan(len);
          $display("txn %0d scan len=%0d user=%0d bv=%0d", t, len, ir_is_user, byte_valid);
        end
        4: begin
          result = $urandom; result_valid = 1'($urandom);
          read_scan(32, got);
          if (ir_is_user)
            check("rand_rd", got, result_valid ? result : 32'h0);
          $display("txn %0d read user=%0d got=%h", t, ir_is_user, got);
        end
        default: begin
          for (int i = 0; i < 6; i++)
            tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0));
          $display("txn %0d mixed controls bv=%0d ovr=%0d", t, byte_valid, overrun);
        end
      endcase
    end

    capture_dr = 0; shift_dr = 0; update_dr = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_bscan_byte_port
